// File: rtl/cr_tlvp_ib_split_if.sv
// cr_tlvp_pkg / cr_tlvp_ib_split_if
//
// Purpose: shared TLV bus types and the handshake bundle of the inbound
// TLV splitter.
//
// Package contents:
//   TLVP_ORD_NUM_WIDTH - width of the per-frame TLV ordinal (ordern)
//   TLVP_TID_WIDTH     - width of the AXI4-S tid field
//   axi4s_dp_bus_t     - inbound 64-bit AXI4-S data-path word
//   tlvp_if_bus_t      - tagged TLV word (sot/eot/ordern/typen/insert)
//
// Interface signals:
//   ib_empty, ib_tlv, ib_rd        - inbound FIFO pop side
//   pt_ib_afull, pt_ib_wr, pt_ib_tlv    - passthrough FIFO push side
//   usr_ib_afull, usr_ib_wr, usr_ib_tlv - user FIFO push side
//   err_bip, err_len, err_trunc    - single-cycle error pulses
// Modports:
//   master - the splitter (pops inbound, pushes outbound, raises errors)
//   slave  - the FIFO / environment side

package cr_tlvp_pkg;

  localparam int TLVP_ORD_NUM_WIDTH = 4;
  localparam int TLVP_TID_WIDTH     = 2;

  typedef struct packed {
    logic [TLVP_TID_WIDTH-1:0] tid;
    logic                      tlast;
    logic [7:0]                tuser;
    logic [7:0]                tstrb;
    logic [63:0]               tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic                          insert;
    logic [TLVP_ORD_NUM_WIDTH-1:0] ordern;
    logic [7:0]                    typen;
    logic                          sot;
    logic                          eot;
    logic [TLVP_TID_WIDTH-1:0]     tid;
    logic                          tlast;
    logic [7:0]                    tuser;
    logic [7:0]                    tstrb;
    logic [63:0]                   tdata;
  } tlvp_if_bus_t;

endpackage

interface cr_tlvp_ib_split_if;
  import cr_tlvp_pkg::*;

  logic          ib_empty;
  axi4s_dp_bus_t ib_tlv;
  logic          ib_rd;

  logic          pt_ib_afull;
  logic          pt_ib_wr;
  tlvp_if_bus_t  pt_ib_tlv;

  logic          usr_ib_afull;
  logic          usr_ib_wr;
  tlvp_if_bus_t  usr_ib_tlv;

  logic          err_bip;
  logic          err_len;
  logic          err_trunc;

  modport master (
    input  ib_empty, ib_tlv, pt_ib_afull, usr_ib_afull,
    output ib_rd, pt_ib_wr, pt_ib_tlv, usr_ib_wr, usr_ib_tlv,
    output err_bip, err_len, err_trunc
  );

  modport slave (
    output ib_empty, ib_tlv, pt_ib_afull, usr_ib_afull,
    input  ib_rd, pt_ib_wr, pt_ib_tlv, usr_ib_wr, usr_ib_tlv,
    input  err_bip, err_len, err_trunc
  );

endinterface

// File: rtl/cr_tlvp_ib_split.sv
// cr_tlvp_ib_split
//
// Purpose: inbound TLV splitter. Pops 64-bit AXI4-S words from the inbound
// FIFO, parses TLV headers, tags every word with sot/eot/ordern/typen and
// steers each whole TLV to the user FIFO (type selected in USR_TYPE_MASK)
// or to the passthrough FIFO. All outputs except ib_rd are registered, so a
// word popped in cycle N is written in cycle N+1.
//
// Parameters:
//   USR_TYPE_MASK - bit t set routes TLVs of type t to the user port
//   N_LEN_BITS    - width of the header length field / word counter
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - cr_tlvp_ib_split_if.master (inbound pop, pt/usr push, errors)

module cr_tlvp_ib_split
  import cr_tlvp_pkg::*;
#(
  parameter logic [255:0] USR_TYPE_MASK = 256'h0,
  parameter int unsigned  N_LEN_BITS    = 16
) (
  input logic                clk,
  input logic                rst,
  cr_tlvp_ib_split_if.master bus
);

  localparam logic [TLVP_ORD_NUM_WIDTH-1:0] ORD_ONE = TLVP_ORD_NUM_WIDTH'(1);
  localparam logic [N_LEN_BITS-1:0]         LEN_ONE = N_LEN_BITS'(1);

  typedef enum logic {HDR, BODY} state_t;

  state_t                        state, state_n;
  logic [N_LEN_BITS-1:0]         remain, remain_n;
  logic                          dest, dest_n;
  logic [7:0]                    typ, typ_n;
  logic [TLVP_ORD_NUM_WIDTH-1:0] cur_ord, ord_n;

  logic                          pt_wr, pt_wr_n;
  logic                          usr_wr, usr_wr_n;
  tlvp_if_bus_t                  pt_tlv, pt_tlv_n;
  tlvp_if_bus_t                  usr_tlv, usr_tlv_n;
  logic                          err_bip_q, err_bip_n;
  logic                          err_len_q, err_len_n;
  logic                          err_trunc_q, err_trunc_n;

  logic                          rd;
  axi4s_dp_bus_t                 in_word;
  logic [7:0]                    hdr_type;
  logic [N_LEN_BITS-1:0]         hdr_len;
  logic [1:0]                    bip;
  tlvp_if_bus_t                  word_n;
  logic                          to_usr;
  logic                          eot;

  // Both afull inputs gate the pop, so a popped word always has room in
  // whichever FIFO it is routed to.
  assign rd       = ~rst & ~bus.ib_empty & ~bus.pt_ib_afull & ~bus.usr_ib_afull;
  assign in_word  = bus.ib_tlv;
  assign hdr_type = in_word.tdata[7:0];
  assign hdr_len  = in_word.tdata[8 +: N_LEN_BITS];

  // BIP2 over {2'b00, tdata[61:0]}: bit 0 covers even bit positions,
  // bit 1 covers odd ones. The top two bits carry the check value itself.
  always_comb begin
    bip = '0;
    for (int unsigned i = 0; i < 31; i++) begin
      bip[0] = bip[0] ^ in_word.tdata[2*i];
      bip[1] = bip[1] ^ in_word.tdata[2*i+1];
    end
  end

  always_comb begin
    state_n     = state;
    remain_n    = remain;
    dest_n      = dest;
    typ_n       = typ;
    ord_n       = cur_ord;
    pt_wr_n     = 1'b0;
    usr_wr_n    = 1'b0;
    pt_tlv_n    = pt_tlv;
    usr_tlv_n   = usr_tlv;
    err_bip_n   = 1'b0;
    err_len_n   = 1'b0;
    err_trunc_n = 1'b0;
    word_n      = '0;
    to_usr      = 1'b0;
    eot         = 1'b0;

    if (rd) begin
      word_n.tdata  = in_word.tdata;
      word_n.tuser  = in_word.tuser;
      word_n.tstrb  = in_word.tstrb;
      word_n.tid    = in_word.tid;
      word_n.tlast  = in_word.tlast;
      word_n.insert = 1'b0;
      word_n.ordern = cur_ord;

      unique case (state)
        HDR: begin
          to_usr       = USR_TYPE_MASK[hdr_type];
          // len 0 is handled as a single-word TLV.
          eot          = (hdr_len <= LEN_ONE) | in_word.tlast;
          err_len_n    = (hdr_len == '0);
          err_bip_n    = (bip != in_word.tdata[63:62]);
          word_n.sot   = 1'b1;
          word_n.typen = hdr_type;
          remain_n     = hdr_len - LEN_ONE;
          dest_n       = to_usr;
          typ_n        = hdr_type;
          if (!eot) begin
            state_n = BODY;
          end
        end
        BODY: begin
          // remain counts body words still expected, including this one.
          to_usr       = dest;
          eot          = (remain == LEN_ONE) | in_word.tlast;
          err_trunc_n  = in_word.tlast & (remain > LEN_ONE);
          word_n.sot   = 1'b0;
          word_n.typen = typ;
          remain_n     = remain - LEN_ONE;
          if (eot) begin
            state_n = HDR;
          end
        end
      endcase

      word_n.eot = eot;

      if (eot) begin
        if (in_word.tlast) begin
          ord_n = ORD_ONE;
        end else if (cur_ord != '1) begin
          ord_n = cur_ord + ORD_ONE;
        end
      end

      if (to_usr) begin
        usr_wr_n  = 1'b1;
        usr_tlv_n = word_n;
      end else begin
        pt_wr_n  = 1'b1;
        pt_tlv_n = word_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HDR;
      remain      <= '0;
      dest        <= 1'b0;
      typ         <= '0;
      cur_ord     <= ORD_ONE;
      pt_wr       <= 1'b0;
      usr_wr      <= 1'b0;
      pt_tlv      <= '0;
      usr_tlv     <= '0;
      err_bip_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_trunc_q <= 1'b0;
    end else begin
      state       <= state_n;
      remain      <= remain_n;
      dest        <= dest_n;
      typ         <= typ_n;
      cur_ord     <= ord_n;
      pt_wr       <= pt_wr_n;
      usr_wr      <= usr_wr_n;
      pt_tlv      <= pt_tlv_n;
      usr_tlv     <= usr_tlv_n;
      err_bip_q   <= err_bip_n;
      err_len_q   <= err_len_n;
      err_trunc_q <= err_trunc_n;
    end
  end

  assign bus.ib_rd      = rd;
  assign bus.pt_ib_wr   = pt_wr;
  assign bus.pt_ib_tlv  = pt_tlv;
  assign bus.usr_ib_wr  = usr_wr;
  assign bus.usr_ib_tlv = usr_tlv;
  assign bus.err_bip    = err_bip_q;
  assign bus.err_len    = err_len_q;
  assign bus.err_trunc  = err_trunc_q;

endmodule

// File: tb/tb_cr_tlvp_ib_split.sv
// tb_cr_tlvp_ib_split
//
// Directed stimulus for cr_tlvp_ib_split with a scoreboard: each accepted
// pop pushes the hand-computed expected word into the pt or usr queue, and a
// monitor on the falling edge pops and compares every write strobe.

module tb_cr_tlvp_ib_split;
  import cr_tlvp_pkg::*;

  localparam int W = TLVP_ORD_NUM_WIDTH;
  localparam logic [255:0] MASK = 256'h20;   // type 5 -> user port
  localparam logic PT  = 1'b0;
  localparam logic USR = 1'b1;

  typedef struct {
    tlvp_if_bus_t tlv;
    logic [2:0]   err;    // {trunc, len, bip}
    int           stamp;  // cycle in which the pop was accepted
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   bp_done = 1'b0;
  exp_t pt_q[$];
  exp_t usr_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cr_tlvp_ib_split_if bus();

  cr_tlvp_ib_split #(
    .USR_TYPE_MASK(MASK),
    .N_LEN_BITS   (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Header word: type, length, filler, BIP2 (optionally corrupted).
  function automatic logic [63:0] hdr(input logic [7:0] t, input logic [15:0] len,
                                      input logic bad);
    logic [63:0] d;
    logic        e;
    logic        o;
    d        = '0;
    d[7:0]   = t;
    d[23:8]  = len;
    d[61:24] = {t, len, ~t, 6'h2A};
    e        = ^(d & 64'h5555_5555_5555_5555);
    o        = ^(d & 64'hAAAA_AAAA_AAAA_AAAA);
    d[63:62] = {o, e ^ bad};
    return d;
  endfunction

  function automatic logic [63:0] body(input int n);
    logic [63:0] d;
    d = 64'hB0D1_0000_C0FE_0000 + 64'(n) * 64'h0001_0001_0003_0101;
    return d;
  endfunction

  task automatic send(input logic [63:0] d, input logic last, input logic to_usr,
                      input logic sot, input logic eot, input logic [W-1:0] ord,
                      input logic [7:0] typ, input logic [2:0] err);
    axi4s_dp_bus_t w;
    tlvp_if_bus_t  e;
    exp_t          x;
    bit            ok;
    w.tdata  = d;
    w.tuser  = d[15:8] ^ 8'h5A;
    w.tstrb  = 8'hFF >> d[2:0];
    w.tid    = d[9:8];
    w.tlast  = last;
    e.tdata  = w.tdata;
    e.tuser  = w.tuser;
    e.tstrb  = w.tstrb;
    e.tid    = w.tid;
    e.tlast  = last;
    e.insert = 1'b0;
    e.ordern = ord;
    e.typen  = typ;
    e.sot    = sot;
    e.eot    = eot;
    bus.ib_tlv   = w;
    bus.ib_empty = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (bus.ib_rd) begin
        x.tlv   = e;
        x.err   = err;
        x.stamp = cyc;
        if (to_usr) usr_q.push_back(x);
        else        pt_q.push_back(x);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: ib_rd=0 for 200 cycles, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.ib_empty = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if (bus.ib_rd || bus.pt_ib_wr || bus.usr_ib_wr || bus.pt_ib_tlv != '0 ||
        bus.usr_ib_tlv != '0 || bus.err_bip || bus.err_len || bus.err_trunc) begin
      errors++;
      $display("FAIL %s: rd=%b ptwr=%b usrwr=%b pt=%h usr=%h err=%b%b%b, required all 0",
               tag, bus.ib_rd, bus.pt_ib_wr, bus.usr_ib_wr, bus.pt_ib_tlv, bus.usr_ib_tlv,
               bus.err_trunc, bus.err_len, bus.err_bip);
    end
  endtask

  task automatic compare(input string tag, input tlvp_if_bus_t act, input exp_t x);
    logic [2:0] err;
    err = {bus.err_trunc, bus.err_len, bus.err_bip};
    checks++;
    if (act !== x.tlv || err !== x.err || cyc != x.stamp + 1) begin
      errors++;
      $display("FAIL %s word: got tlv=%h err=%b cyc=%0d, required tlv=%h err=%b cyc=%0d",
               tag, act, err, cyc, x.tlv, x.err, x.stamp + 1);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t x;
    if (bus.pt_ib_wr) begin
      if (pt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pt_unexpected: got tlv=%h, required no write", bus.pt_ib_tlv);
      end else begin
        x = pt_q.pop_front();
        compare("pt", bus.pt_ib_tlv, x);
      end
    end
    if (bus.usr_ib_wr) begin
      if (usr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL usr_unexpected: got tlv=%h, required no write", bus.usr_ib_tlv);
      end else begin
        x = usr_q.pop_front();
        compare("usr", bus.usr_ib_tlv, x);
      end
    end
    if (!bus.pt_ib_wr && !bus.usr_ib_wr && !rst) begin
      checks++;
      if (bus.err_bip || bus.err_len || bus.err_trunc) begin
        errors++;
        $display("FAIL idle_err: got err=%b%b%b without write, required 000",
                 bus.err_trunc, bus.err_len, bus.err_bip);
      end
    end
    if (bus.usr_ib_afull) begin
      checks++;
      if (bus.ib_rd) begin
        errors++;
        $display("FAIL afull_rd: got ib_rd=1 while usr_ib_afull=1, required 0");
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bus.ib_empty     = 1'b0;
    bus.ib_tlv       = '0;
    bus.pt_ib_afull  = 1'b0;
    bus.usr_ib_afull = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset("reset_state");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Mixed routing: type 3 len 2, type 5 len 3, type 3 len 1 with tlast.
    send(hdr(8'd3, 16'd2, 1'b0), 1'b0, PT,  1'b1, 1'b0, 4'd1, 8'd3, 3'b000);
    send(body(1),                1'b0, PT,  1'b0, 1'b1, 4'd1, 8'd3, 3'b000);
    send(hdr(8'd5, 16'd3, 1'b0), 1'b0, USR, 1'b1, 1'b0, 4'd2, 8'd5, 3'b000);
    send(body(2),                1'b0, USR, 1'b0, 1'b0, 4'd2, 8'd5, 3'b000);
    send(body(3),                1'b0, USR, 1'b0, 1'b1, 4'd2, 8'd5, 3'b000);
    send(hdr(8'd3, 16'd1, 1'b0), 1'b1, PT,  1'b1, 1'b1, 4'd3, 8'd3, 3'b000);
    idle(3);

    // Ordinal restart: two frames of two single-word TLVs.
    send(hdr(8'd3, 16'd1, 1'b0), 1'b0, PT,  1'b1, 1'b1, 4'd1, 8'd3, 3'b000);
    send(hdr(8'd5, 16'd1, 1'b0), 1'b1, USR, 1'b1, 1'b1, 4'd2, 8'd5, 3'b000);
    send(hdr(8'd3, 16'd1, 1'b0), 1'b0, PT,  1'b1, 1'b1, 4'd1, 8'd3, 3'b000);
    send(hdr(8'd3, 16'd1, 1'b0), 1'b1, PT,  1'b1, 1'b1, 4'd2, 8'd3, 3'b000);
    idle(3);

    // Backpressure: usr_ib_afull toggles every 3 cycles across a 10-word TLV.
    bp_done = 1'b0;
    fork
      begin
        while (!bp_done) begin
          repeat (3) @(posedge clk);
          #1;
          bus.usr_ib_afull = ~bus.usr_ib_afull;
        end
        bus.usr_ib_afull = 1'b0;
      end
    join_none
    send(hdr(8'd5, 16'd10, 1'b0), 1'b0, USR, 1'b1, 1'b0, 4'd1, 8'd5, 3'b000);
    for (int i = 0; i < 8; i++)
      send(body(10 + i), 1'b0, USR, 1'b0, 1'b0, 4'd1, 8'd5, 3'b000);
    send(body(18), 1'b1, USR, 1'b0, 1'b1, 4'd1, 8'd5, 3'b000);
    bus.ib_empty = 1'b1;
    bp_done = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    idle(2);

    // Errors: bad BIP2, len 0, both at once, truncation.
    send(hdr(8'd3, 16'd1, 1'b1), 1'b1, PT,  1'b1, 1'b1, 4'd1, 8'd3, 3'b001);
    send(hdr(8'd3, 16'd0, 1'b0), 1'b1, PT,  1'b1, 1'b1, 4'd1, 8'd3, 3'b010);
    send(hdr(8'd5, 16'd0, 1'b1), 1'b1, USR, 1'b1, 1'b1, 4'd1, 8'd5, 3'b011);
    send(hdr(8'd3, 16'd1, 1'b0), 1'b0, PT,  1'b1, 1'b1, 4'd1, 8'd3, 3'b000);
    send(hdr(8'd5, 16'd6, 1'b0), 1'b0, USR, 1'b1, 1'b0, 4'd2, 8'd5, 3'b000);
    send(body(30),               1'b0, USR, 1'b0, 1'b0, 4'd2, 8'd5, 3'b000);
    send(body(31),               1'b1, USR, 1'b0, 1'b1, 4'd2, 8'd5, 3'b100);
    send(hdr(8'd3, 16'd1, 1'b0), 1'b1, PT,  1'b1, 1'b1, 4'd1, 8'd3, 3'b000);
    idle(3);

    // Reset during word 2 of a 4-word TLV (second TLV of its frame).
    send(hdr(8'd3, 16'd1, 1'b0), 1'b0, PT,  1'b1, 1'b1, 4'd1, 8'd3, 3'b000);
    send(hdr(8'd3, 16'd4, 1'b0), 1'b0, PT,  1'b1, 1'b0, 4'd2, 8'd3, 3'b000);
    send(body(40),               1'b0, PT,  1'b0, 1'b0, 4'd2, 8'd3, 3'b000);
    rst = 1'b1;
    bus.ib_tlv.tdata = body(41);
    bus.ib_empty = 1'b0;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check_reset("mid_reset");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(hdr(8'd5, 16'd1, 1'b0), 1'b1, USR, 1'b1, 1'b1, 4'd1, 8'd5, 3'b000);
    idle(3);

    // Ordinal saturation: 2^W+1 single-word TLVs in one frame.
    for (int i = 0; i < (1 << W) + 1; i++)
      send(hdr(8'd3, 16'd1, 1'b0), (i == (1 << W)), PT, 1'b1, 1'b1,
           (i < (1 << W) - 1) ? W'(i + 1) : '1, 8'd3, 3'b000);
    send(hdr(8'd3, 16'd1, 1'b0), 1'b1, PT, 1'b1, 1'b1, 4'd1, 8'd3, 3'b000);
    idle(4);

    checks++;
    if (pt_q.size() != 0 || usr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending pt=%0d usr=%0d, required 0 0", pt_q.size(), usr_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_tlvp_ib_split.md
# cr_tlvp_ib_split

Inbound TLV splitter: the receive-side counterpart of the outbound TLV reassembly/merge block. It pops 64-bit AXI4-S data-path words from the inbound FIFO, parses TLV headers, and tags each word with sot/eot/ordern/typen. Each whole TLV goes to the user FIFO if its type is selected in `USR_TYPE_MASK`, otherwise to the passthrough FIFO. Ordinal numbering matches the outbound merger: first TLV of a frame is 1, and numbering restarts after tlast.

## Interface
- `USR_TYPE_MASK`, default 256'h0: bit t set routes TLVs of type t to the user port.
- `N_LEN_BITS`, default 16: width of the header length field and the word counter.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `ib_empty` in 1: inbound FIFO empty.
- `ib_tlv` in $bits(axi4s_dp_bus_t): inbound word, with tdata[63:0], tuser[7:0], tstrb[7:0], tid, tlast.
- `ib_rd` out 1: pop inbound FIFO.
- `pt_ib_afull` in 1: passthrough FIFO almost full.
- `pt_ib_wr` out 1: passthrough write strobe.
- `pt_ib_tlv` out $bits(tlvp_if_bus_t): passthrough word.
- `usr_ib_afull` in 1: user FIFO almost full.
- `usr_ib_wr` out 1: user write strobe.
- `usr_ib_tlv` out $bits(tlvp_if_bus_t): user word.
- `err_bip` out 1: one-cycle pulse on a header BIP2 mismatch.
- `err_len` out 1: one-cycle pulse on a zero-length header.
- `err_trunc` out 1: one-cycle pulse on tlast before the header length is exhausted.

## Operation
**Header format** (word 0 of each TLV):
- tdata[7:0] = type.
- tdata[8+N_LEN_BITS-1:8] = length in 64-bit words, including the header.
- tdata[63:62] = BIP2 of {2'b00, tdata[61:0]}.

**Read rule:** `ib_rd = ~ib_empty & ~pt_ib_afull & ~usr_ib_afull`. Both afull inputs gate the read, so routing never depends on a stalled target.

**State machine:**
- HDR (reset state):
  - The popped word is a header. Latch type and route: `dest = USR_TYPE_MASK[type]`.
  - Set `remain = len - 1`.
  - Emit the word with sot=1, typen=type, ordern=cur_ord.
  - If len ≤ 1 or tlast=1: emit with eot=1 and stay in HDR. Otherwise go to BODY.
- BODY:
  - Each popped word is sent to the latched dest with sot=0 and the same typen/ordern, and decrements remain.
  - When remain reaches 1, or tlast=1: set eot=1, then go to HDR.

**Ordinal (cur_ord, width TLVP_ORD_NUM_WIDTH):**
- Reset value 1.
- On the eot word of a TLV: if tlast, set to 1; else increment, saturating at all-ones. There is no wrap.

**Field mapping:**
- tdata, tuser, tstrb, tid and tlast are copied unchanged.
- insert=0 always.
- tuser[0] is not interpreted.

**Errors (word is still forwarded in all cases):**
- len=0: treated as len 1 (single-word TLV); pulse err_len.
- BIP2 mismatch: pulse err_bip.
- tlast in BODY with remain > 1: force eot=1, pulse err_trunc, return to HDR; cur_ord becomes 1.
- Both err_len and err_bip may pulse in the same cycle.

**Reset mid-TLV:** state returns to HDR, cur_ord=1, all outputs 0. The next popped word is parsed as a header.

## Timing
- Registered outputs. A word popped in cycle N appears with its wr strobe in cycle N+1.
- Sustained throughput is 1 word/clock.
- Exactly one of pt_ib_wr/usr_ib_wr is asserted per popped word. Both are 0 when nothing was popped.
- Error pulses align with the write strobe of the offending word.
- Afull thresholds must leave ≥1 free entry, to absorb the 1-cycle in-flight word.
- Reset values: ib_rd=0 (combinational, forced 0 while rst), pt_ib_wr=0, usr_ib_wr=0, pt_ib_tlv=0, usr_ib_tlv=0, err_*=0.
- Routing of a TLV is fixed at its header; a stall mid-TLV never changes dest.
- afull asserting in cycle N blocks the pop in cycle N itself. The word popped in N-1 still writes in N.

## Test plan
- **Mixed routing:** mask bit 5 set. Input frame: type 3 len 2, type 5 len 3, type 3 len 1 with tlast. Required:
  - pt receives 2 words (ordern 1, sot/eot on words 1/2), then 1 word (ordern 3, sot=eot=1, tlast=1).
  - usr receives 3 words with ordern 2.
  - Back-to-back, 1-cycle latency.
- **Ordinal restart:** two frames of 2 single-word TLVs each. Required: ordern sequence 1, 2, 1, 2.
- **Backpressure:** toggle usr_ib_afull every 3 cycles during a 10-word user TLV. Required:
  - ib_rd=0 in every afull cycle.
  - All 10 words delivered in order.
  - Exactly one sot and one eot, no duplicate or lost words.
- **Errors:**
  - Header with bad BIP2 → err_bip pulse with the sot word, word still forwarded.
  - len=0 → err_len, single-word TLV.
  - len=6 with tlast on word 3 → err_trunc, eot on word 3, next frame ordern=1.
- **Reset mid-operation:** assert rst during word 2 of a 4-word TLV. Required: outputs 0 during reset; the first word after reset is parsed as a header with ordern=1.
- **Ordinal saturation:** a frame of 2^TLVP_ORD_NUM_WIDTH+1 single-word TLVs. Required: ordern holds at all-ones and does not wrap to 0.
